// File: rtl/exec_command_pkg.sv
// Shared definitions for the LCD command executor: opcodes, FSM states,
// long-running instruction codes and the tick-count helper.
// Latency: n/a (types and functions only). Backpressure: n/a.
package exec_command_pkg;

  localparam int CNT_W = 20;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;

  // Command byte bits [7:6].
  typedef enum logic [1:0] {
    OP_DATA  = 2'b00,
    OP_INSTR = 2'b01,
    OP_DELAY = 2'b10,
    OP_NOP   = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_GET_OPERAND = 3'd1,
    ST_SETUP       = 3'd2,
    ST_EHIGH       = 3'd3,
    ST_HOLD        = 3'd4,
    ST_WAIT        = 3'd5
  } state_e;

  // Clear-display and return-home need the long settle time.
  localparam logic [7:0] INSTR_CLEAR = 8'h01;
  localparam logic [7:0] INSTR_HOME  = 8'h02;

  function automatic logic is_long_instr(input logic [7:0] b);
    return (b == INSTR_CLEAR) || (b == INSTR_HOME);
  endfunction

  // Counter reload value for a phase lasting 'ticks' cycles: ticks-1,
  // floored at 0 and saturated to the counter width so it never wraps.
  function automatic cnt_t last_tick(input logic [31:0] ticks);
    logic [31:0] m1;
    m1 = (ticks == 32'd0) ? 32'd0 : ticks - 32'd1;
    if (m1 > {{(32-CNT_W){1'b0}}, CNT_MAX})
      return CNT_MAX;
    else
      return m1[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/exec_command_if.sv
// Byte handoff from the command reader into the executor's shared register.
// Latency: n/a (wires only). Backpressure: reader must not send while
// cmdreg_data_avail is high; bytes sent then are dropped.
// master = command reader, slave = exec_command.
interface exec_command_if;
  logic       cmdreg_wr;          // write strobe, may be held several cycles
  logic [7:0] cmdreg_data_send;   // byte to load
  logic       cmdreg_data_avail;  // shared register holds an unconsumed byte

  modport master (
    output cmdreg_wr,
    output cmdreg_data_send,
    input  cmdreg_data_avail
  );

  modport slave (
    input  cmdreg_wr,
    input  cmdreg_data_send,
    output cmdreg_data_avail
  );
endinterface

// File: rtl/cmd_shared_reg.sv
// One-byte shared register loaded on the rising edge of a write strobe.
// Latency: avail rises the cycle after the wr edge; clears the cycle after consume.
// Backpressure: wr edges while a byte is pending (and not being consumed) are dropped.
// Ports: clk, rst (sync, active-high); wr/data_send from the reader;
//        consume from the sequencer; avail/data to the sequencer.
module cmd_shared_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic [7:0] data_send,
  input  logic       consume,
  output logic       avail,
  output logic [7:0] data
);

  logic wr_hist;
  logic wr_rise;

  // History resets to 1 so a strobe already high at reset release is not a new edge.
  assign wr_rise = wr & ~wr_hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_hist <= 1'b1;
      avail   <= 1'b0;
      data    <= 8'h00;
    end else begin
      wr_hist <= wr;
      // A byte being consumed this cycle frees the slot for a same-cycle load.
      if (wr_rise && (!avail || consume)) begin
        data  <= data_send;
        avail <= 1'b1;
      end else if (consume) begin
        avail <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/exec_command.sv
// Executes LCD command bytes: data/instruction writes with timed E strobe, delays, NOPs.
// Latency: byte consumed the cycle after avail; write = SETUP+EHIGH+HOLD+WAIT cycles.
// Backpressure: bytes are only consumed in IDLE/GET_OPERAND; upstream watches cmdreg_data_avail.
// Ports: clk, rst (sync, active-high); cmd (slave byte handoff);
//        lcd_rs/lcd_e/lcd_d display bus; busy = sequencer not idle.
module exec_command
  import exec_command_pkg::*;
#(
  parameter int T_SETUP = 4,
  parameter int T_EHIGH = 24,
  parameter int T_HOLD  = 4,
  parameter int T_SHORT = 4800,
  parameter int T_LONG  = 196800,
  parameter int T_UNIT  = 120
) (
  input  logic               clk,
  input  logic               rst,
  exec_command_if.slave      cmd,
  output logic               lcd_rs,
  output logic               lcd_e,
  output logic [7:0]         lcd_d,
  output logic               busy
);

  localparam cnt_t SETUP_LAST = last_tick(32'(T_SETUP));
  localparam cnt_t EHIGH_LAST = last_tick(32'(T_EHIGH));
  localparam cnt_t HOLD_LAST  = last_tick(32'(T_HOLD));
  localparam cnt_t SHORT_LAST = last_tick(32'(T_SHORT));
  localparam cnt_t LONG_LAST  = last_tick(32'(T_LONG));

  state_e      state;
  cnt_t        cnt;
  logic        pend_rs;     // RS chosen by the opcode, applied with the operand
  logic        reg_avail;
  logic [7:0]  reg_data;
  logic        consume;
  opcode_e     op;
  logic [31:0] delay_ticks;

  assign consume = reg_avail && ((state == ST_IDLE) || (state == ST_GET_OPERAND));
  assign op      = opcode_e'(reg_data[7:6]);
  // 6-bit count times a 20-bit unit fits in 26 bits; last_tick saturates to 20.
  assign delay_ticks = 32'(reg_data[5:0]) * 32'(T_UNIT);

  assign cmd.cmdreg_data_avail = reg_avail;

  cmd_shared_reg u_shared_reg (
    .clk       (clk),
    .rst       (rst),
    .wr        (cmd.cmdreg_wr),
    .data_send (cmd.cmdreg_data_send),
    .consume   (consume),
    .avail     (reg_avail),
    .data      (reg_data)
  );

  // Each timed phase loads cnt with (length-1) on entry and leaves when it hits 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pend_rs <= 1'b0;
      lcd_e   <= 1'b0;
      lcd_rs  <= 1'b0;
      lcd_d   <= 8'h00;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (reg_avail) begin
            case (op)
              OP_DATA, OP_INSTR: begin
                pend_rs <= (op == OP_DATA);
                state   <= ST_GET_OPERAND;
                busy    <= 1'b1;
              end
              OP_DELAY: begin
                if (reg_data[5:0] != 6'd0) begin
                  cnt   <= last_tick(delay_ticks);
                  state <= ST_WAIT;
                  busy  <= 1'b1;
                end
              end
              default: ;  // NOP: byte consumed, nothing else happens
            endcase
          end
        end
        ST_GET_OPERAND: begin
          if (reg_avail) begin
            lcd_d  <= reg_data;
            lcd_rs <= pend_rs;
            cnt    <= SETUP_LAST;
            state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            lcd_e <= 1'b1;
            cnt   <= EHIGH_LAST;
            state <= ST_EHIGH;
          end else begin
            cnt <= cnt - cnt_t'(1);
          end
        end
        ST_EHIGH: begin
          if (cnt == '0) begin
            lcd_e <= 1'b0;
            cnt   <= HOLD_LAST;
            state <= ST_HOLD;
          end else begin
            cnt <= cnt - cnt_t'(1);
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            cnt   <= (!lcd_rs && is_long_instr(lcd_d)) ? LONG_LAST : SHORT_LAST;
            state <= ST_WAIT;
          end else begin
            cnt <= cnt - cnt_t'(1);
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - cnt_t'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          lcd_e <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/exec_command.md
EXEC_COMMAND -- requirements
Module: exec_command

Interface
REQ-001 Parameters SHALL be: T_SETUP, 4, ticks RS/data stable before lcd_e rises.
REQ-002 T_EHIGH, 24, ticks lcd_e held high.
REQ-003 T_HOLD, 4, ticks RS/data held after lcd_e falls.
REQ-004 T_SHORT, 4800, post-write wait ticks, normal instruction/data.
REQ-005 T_LONG, 196800, post-write wait ticks after instruction 0x01 or 0x02.
REQ-006 T_UNIT, 120, ticks per delay-command unit.
REQ-007 clk  input  1  single system clock; all logic on rising edge.
REQ-008 rst  input  1  reset, synchronous and active-high.
REQ-009 cmdreg_wr  input  1  shared-register write strobe from command reader; may stay high several cycles.
REQ-010 cmdreg_data_send  input  8  byte to load into shared register.
REQ-011 cmdreg_data_avail  output  1  shared register holds an unconsumed byte.
REQ-012 lcd_rs  output  1  register select; 1 = data, 0 = instruction.
REQ-013 lcd_e  output  1  display enable strobe.
REQ-014 lcd_d  output  8  display data bus.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 Shared register SHALL load cmdreg_data_send on the first cycle cmdreg_wr is high after being low (rising-edge detect), only if cmdreg_data_avail is 0; cmdreg_data_avail SHALL be 1 the following cycle.
REQ-017 A wr rising edge while cmdreg_data_avail=1 SHALL be ignored (byte dropped, register unchanged); a wr held high SHALL load exactly once.
REQ-018 Consuming a byte SHALL clear cmdreg_data_avail on the next cycle; simultaneous consume and wr rising edge SHALL load the new byte and leave cmdreg_data_avail=1.
REQ-019 Opcode byte[7:6]: 00 = data write (next byte operand, RS=1); 01 = instruction write (next byte operand, RS=0); 10 = delay byte[5:0]*T_UNIT ticks; 11 = NOP (consumed, no action).
REQ-020 States SHALL be IDLE, GET_OPERAND, SETUP, EHIGH, HOLD, WAIT.
REQ-021 IDLE: on cmdreg_data_avail=1 consume byte; 00/01 -> GET_OPERAND; 10 with count>0 -> WAIT; 10 with count 0 or 11 -> stay IDLE.
REQ-022 GET_OPERAND: on cmdreg_data_avail=1 consume byte, drive lcd_d=operand and lcd_rs per opcode, -> SETUP.
REQ-023 SETUP lasts T_SETUP cycles, EHIGH T_EHIGH cycles with lcd_e=1, HOLD T_HOLD cycles, then WAIT.
REQ-024 WAIT length: T_LONG if RS=0 and operand is 0x01 or 0x02, else T_SHORT; delay command uses byte[5:0]*T_UNIT; then IDLE.
REQ-025 lcd_d and lcd_rs SHALL remain constant from SETUP entry through end of WAIT.
REQ-026 Single 20-bit down/up tick counter SHALL time SETUP/EHIGH/HOLD/WAIT; products and compares at 20 bits, no wrap permitted for any parameter value <= 2^20-1.
REQ-027 No byte is consumed outside IDLE and GET_OPERAND; upstream back-pressure is via cmdreg_data_avail only.

Reset
REQ-028 rst=1 at a clock edge SHALL force state IDLE, counter 0, cmdreg_data_avail 0, lcd_e 0, lcd_rs 0, lcd_d 0x00, busy 0, wr edge-detect history 1 (a wr already high at reset release SHALL NOT load).
REQ-029 Reset mid-operation (including EHIGH) SHALL drop lcd_e low on the next edge and discard any pending byte and partial command.

Structure
REQ-030 Opcode encodings, state encoding and the 0x01/0x02 long-instruction codes SHALL live in shared package exec_command_pkg.
REQ-031 The shared register with edge-detect SHALL be sub-module cmd_shared_reg; sequencer remains in exec_command.

Verification (bench parameters T_SETUP=2, T_EHIGH=3, T_HOLD=2, T_SHORT=5, T_LONG=20, T_UNIT=4)
REQ-032 Bytes 0x00,0x41 -> lcd_rs=1, lcd_d=0x41, lcd_e high exactly 3 cycles after 2 setup cycles, busy low 5 wait cycles after HOLD.
REQ-033 Bytes 0x40,0x01 -> lcd_rs=0, lcd_d=0x01, WAIT lasts 20 cycles; 0x40,0x38 -> WAIT 5 cycles.
REQ-034 Byte 0x83 -> no lcd_e pulse, busy high 12 cycles; 0x80 and 0xC0 -> no pulse, busy stays 0.
REQ-035 cmdreg_wr held high 2 cycles with 0x55 -> one load; second wr edge while avail=1 -> dropped, register still 0x55.
REQ-036 rst asserted during EHIGH -> next edge lcd_e=0, cmdreg_data_avail=0, state IDLE; following 0x00,0x20 executes normally.
